// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcodes and execute-stage FSM states.
package cpu_pkg;

  localparam int unsigned DATA_W    = 24;
  localparam int unsigned DEST_W    = 4;
  localparam int unsigned MUL_ITERS = 24;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_SLL    = 4'd5,
    OP_SRL    = 4'd6,
    OP_SRA    = 4'd7,
    OP_MUL    = 4'd8,
    OP_PASS_B = 4'd9,
    OP_SLT    = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } exec_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, low Width bits of the product.
module seq_multiplier
  import cpu_pkg::*;
#(
  parameter int unsigned Width = DATA_W,
  parameter int unsigned Iters = MUL_ITERS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [Width-1:0] op_a,
  input  logic [Width-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] product
);

  localparam int unsigned CntW = $clog2(Iters);

  exec_state_t     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [Width-1:0] mcand_q, mcand_d;
  logic [Width-1:0] mplier_q, mplier_d;
  logic [Width-1:0] acc_q, acc_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = MUL_BUSY;
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      MUL_BUSY: begin
        // Bits shifted past the top of mcand only affect product bits we discard.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(Iters - 1)) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign busy    = (state_q == MUL_BUSY);
  assign done    = (state_q == MUL_DONE);
  assign product = acc_q;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU with a stalling iterative multiply, feeding the ALU/memory
// pipe register combinationally.
module execute_stage #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned DEST_W = cpu_pkg::DEST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              flush,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [DATA_W-1:0] store_data,
  input  logic              writeback_enable,
  input  logic              mem_read_enable,
  input  logic              mem_write_enable,
  input  logic [DEST_W-1:0] instruction_dest,
  output logic              stall,
  output logic              writeback_enable_out,
  output logic              mem_read_enable_out,
  output logic              mem_write_enable_out,
  output logic [DEST_W-1:0] instruction_dest_out,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] write_data,
  output logic              zero_flag,
  output logic              negative_flag
);

  import cpu_pkg::*;

  alu_op_t           op;
  logic [4:0]        shamt;
  logic              shift_oob;
  logic              slt;
  logic [DATA_W-1:0] alu_comb;

  logic              mul_issue, mul_busy, mul_done;
  logic [DATA_W-1:0] product;
  logic              bubble;
  logic [DATA_W-1:0] res;

  // Control captured at multiply issue, replayed when the product is presented.
  logic              hold_valid_q, hold_valid_d;
  logic              hold_wb_q, hold_wb_d;
  logic              hold_rd_q, hold_rd_d;
  logic              hold_wr_q, hold_wr_d;
  logic [DEST_W-1:0] hold_dest_q, hold_dest_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;

  assign op        = alu_op_t'(alu_op);
  assign shamt     = operand_b[4:0];
  assign shift_oob = (32'(shamt) >= DATA_W);
  assign slt       = ($signed(operand_a) < $signed(operand_b));

  always_comb begin
    alu_comb = '0;
    case (op)
      OP_ADD:    alu_comb = operand_a + operand_b;
      OP_SUB:    alu_comb = operand_a - operand_b;
      OP_AND:    alu_comb = operand_a & operand_b;
      OP_OR:     alu_comb = operand_a | operand_b;
      OP_XOR:    alu_comb = operand_a ^ operand_b;
      OP_SLL:    alu_comb = shift_oob ? '0 : (operand_a << shamt);
      OP_SRL:    alu_comb = shift_oob ? '0 : (operand_a >> shamt);
      OP_SRA:    alu_comb = shift_oob ? {DATA_W{operand_a[DATA_W-1]}}
                                      : DATA_W'($signed(operand_a) >>> shamt);
      OP_PASS_B: alu_comb = operand_b;
      OP_SLT:    alu_comb = {{(DATA_W - 1){1'b0}}, slt};
      default:   alu_comb = '0;
    endcase
  end

  assign mul_issue = rst && !flush && valid_in && !mul_busy && !mul_done && (op == OP_MUL);
  assign stall     = mul_issue || (rst && !flush && mul_busy);

  seq_multiplier #(
    .Width (DATA_W),
    .Iters (MUL_ITERS)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_issue),
    .flush   (flush),
    .op_a    (operand_a),
    .op_b    (operand_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_wb_d    = hold_wb_q;
    hold_rd_d    = hold_rd_q;
    hold_wr_d    = hold_wr_q;
    hold_dest_d  = hold_dest_q;
    hold_wdata_d = hold_wdata_q;
    if (mul_issue) begin
      hold_valid_d = 1'b1;
      hold_wb_d    = writeback_enable;
      hold_rd_d    = mem_read_enable;
      hold_wr_d    = mem_write_enable;
      hold_dest_d  = instruction_dest;
      hold_wdata_d = store_data;
    end else if (mul_busy && !valid_in) begin
      // Upstream dropped the instruction mid-multiply; finish but never emit it.
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_valid_q <= 1'b0;
      hold_wb_q    <= 1'b0;
      hold_rd_q    <= 1'b0;
      hold_wr_q    <= 1'b0;
      hold_dest_q  <= '0;
      hold_wdata_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_wb_q    <= hold_wb_d;
      hold_rd_q    <= hold_rd_d;
      hold_wr_q    <= hold_wr_d;
      hold_dest_q  <= hold_dest_d;
      hold_wdata_q <= hold_wdata_d;
    end
  end

  assign bubble = !rst || flush || stall || !valid_in || (mul_done && !hold_valid_q);

  always_comb begin
    res                  = '0;
    writeback_enable_out = 1'b0;
    mem_read_enable_out  = 1'b0;
    mem_write_enable_out = 1'b0;
    instruction_dest_out = '0;
    write_data           = '0;
    zero_flag            = 1'b0;
    negative_flag        = 1'b0;
    if (!bubble) begin
      if (mul_done) begin
        res                  = product;
        writeback_enable_out = hold_wb_q;
        mem_read_enable_out  = hold_rd_q;
        mem_write_enable_out = hold_wr_q;
        instruction_dest_out = hold_dest_q;
        write_data           = hold_wdata_q;
      end else begin
        res                  = alu_comb;
        writeback_enable_out = writeback_enable;
        mem_read_enable_out  = mem_read_enable;
        mem_write_enable_out = mem_write_enable;
        instruction_dest_out = instruction_dest;
        write_data           = store_data;
      end
      zero_flag     = (res == '0);
      negative_flag = res[DATA_W-1];
    end
  end

  assign alu_result = res;

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage: ALU ops, shift limits, multiply stall timing,
// flush, protocol-violation and mid-multiply reset.
module tb_execute_stage;

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_AND  = 4'd2;
  localparam logic [3:0] A_OR   = 4'd3;
  localparam logic [3:0] A_XOR  = 4'd4;
  localparam logic [3:0] A_SLL  = 4'd5;
  localparam logic [3:0] A_SRL  = 4'd6;
  localparam logic [3:0] A_SRA  = 4'd7;
  localparam logic [3:0] A_MUL  = 4'd8;
  localparam logic [3:0] A_PASS = 4'd9;
  localparam logic [3:0] A_SLT  = 4'd10;

  logic        clk = 1'b0;
  logic        rst, valid_in, flush;
  logic [3:0]  alu_op;
  logic [23:0] operand_a, operand_b, store_data;
  logic        writeback_enable, mem_read_enable, mem_write_enable;
  logic [3:0]  instruction_dest;
  logic        stall, writeback_enable_out, mem_read_enable_out, mem_write_enable_out;
  logic [3:0]  instruction_dest_out;
  logic [23:0] alu_result, write_data;
  logic        zero_flag, negative_flag;

  int vecs  = 0;
  int fails = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .valid_in             (valid_in),
    .flush                (flush),
    .alu_op               (alu_op),
    .operand_a            (operand_a),
    .operand_b            (operand_b),
    .store_data           (store_data),
    .writeback_enable     (writeback_enable),
    .mem_read_enable      (mem_read_enable),
    .mem_write_enable     (mem_write_enable),
    .instruction_dest     (instruction_dest),
    .stall                (stall),
    .writeback_enable_out (writeback_enable_out),
    .mem_read_enable_out  (mem_read_enable_out),
    .mem_write_enable_out (mem_write_enable_out),
    .instruction_dest_out (instruction_dest_out),
    .alu_result           (alu_result),
    .write_data           (write_data),
    .zero_flag            (zero_flag),
    .negative_flag        (negative_flag)
  );

  task automatic drive(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] sd, input logic [3:0] dest, input logic wb,
                       input logic rd, input logic wr);
    alu_op           = op;
    operand_a        = a;
    operand_b        = b;
    store_data       = sd;
    instruction_dest = dest;
    writeback_enable = wb;
    mem_read_enable  = rd;
    mem_write_enable = wr;
    valid_in         = 1'b1;
    flush            = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Samples on the falling edge; outputs are combinational from inputs driven after posedge.
  task automatic expect_out(input string tag, input logic e_stall, input logic e_wb,
                            input logic e_rd, input logic e_wr, input logic [3:0] e_dest,
                            input logic [23:0] e_res, input logic [23:0] e_wd,
                            input logic e_z, input logic e_n);
    logic [57:0] obs, exp;
    @(negedge clk);
    obs = {stall, writeback_enable_out, mem_read_enable_out, mem_write_enable_out,
           instruction_dest_out, alu_result, write_data, zero_flag, negative_flag};
    exp = {e_stall, e_wb, e_rd, e_wr, e_dest, e_res, e_wd, e_z, e_n};
    vecs++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_bubble(input string tag, input logic e_stall);
    expect_out(tag, e_stall, 1'b0, 1'b0, 1'b0, 4'h0, 24'h0, 24'h0, 1'b0, 1'b0);
  endtask

  // Plain ALU vector: fixed control, flags derived from the expected result.
  task automatic alu_vec(input string tag, input logic [3:0] op, input logic [23:0] a,
                         input logic [23:0] b, input logic [23:0] e_res);
    drive(op, a, b, 24'h5A5A5A, 4'hA, 1'b1, 1'b0, 1'b0);
    expect_out(tag, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA, e_res, 24'h5A5A5A,
               (e_res == 24'h0), e_res[23]);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vecs=%0d", vecs);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset holds outputs at bubble even with a valid instruction presented.
    rst = 1'b0;
    drive(A_ADD, 24'h000001, 24'h000002, 24'h111111, 4'h3, 1'b1, 1'b1, 1'b1);
    expect_bubble("reset_c0", 1'b0);
    next_cycle();
    expect_bubble("reset_c1", 1'b0);
    next_cycle();

    rst = 1'b1;
    drive(A_ADD, 24'hFFFFFF, 24'h000002, 24'hABCDEF, 4'h5, 1'b1, 1'b0, 1'b0);
    expect_out("add_wrap", 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 24'h000001, 24'hABCDEF, 1'b0, 1'b0);
    next_cycle();

    alu_vec("sra_30", A_SRA, 24'h800000, 24'h00001E, 24'hFFFFFF);
    alu_vec("sll_24", A_SLL, 24'h000001, 24'h000018, 24'h000000);
    alu_vec("sra_4", A_SRA, 24'h800000, 24'h000004, 24'hF80000);
    alu_vec("srl_3_hibits", A_SRL, 24'h800000, 24'h000103, 24'h100000);
    alu_vec("srl_31", A_SRL, 24'hFFFFFF, 24'h00001F, 24'h000000);
    alu_vec("and", A_AND, 24'hF0F0F0, 24'h3C3C3C, 24'h303030);
    alu_vec("or", A_OR, 24'hF0F0F0, 24'h3C3C3C, 24'hFCFCFC);
    alu_vec("xor", A_XOR, 24'hF0F0F0, 24'h3C3C3C, 24'hCCCCCC);
    alu_vec("sub_wrap", A_SUB, 24'h000000, 24'h000001, 24'hFFFFFF);
    alu_vec("slt_true", A_SLT, 24'hFFFFFF, 24'h000001, 24'h000001);
    alu_vec("slt_false", A_SLT, 24'h000001, 24'hFFFFFF, 24'h000000);

    drive(A_PASS, 24'h123456, 24'h00ABCD, 24'h55AA55, 4'h2, 1'b0, 1'b1, 1'b1);
    expect_out("pass_b_ctl", 1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 24'h00ABCD, 24'h55AA55, 1'b0, 1'b0);
    next_cycle();
    drive(4'd12, 24'h123456, 24'h654321, 24'h0F0F0F, 4'h7, 1'b1, 1'b0, 1'b1);
    expect_out("op12_zero", 1'b0, 1'b1, 1'b0, 1'b1, 4'h7, 24'h000000, 24'h0F0F0F, 1'b1, 1'b0);
    next_cycle();
    drive(A_ADD, 24'h000010, 24'h000020, 24'h0F0F0F, 4'h7, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    expect_bubble("flush_add", 1'b0);
    next_cycle();
    drive(A_ADD, 24'h000010, 24'h000020, 24'h0F0F0F, 4'h7, 1'b1, 1'b0, 1'b0);
    valid_in = 1'b0;
    expect_bubble("invalid_add", 1'b0);
    next_cycle();

    // Multiply: 25 stall cycles of bubbles, product on the 26th.
    drive(A_MUL, 24'h001000, 24'h000300, 24'h123456, 4'h9, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 25; c++) begin
      expect_bubble($sformatf("mul1_stall_c%0d", c), 1'b1);
      next_cycle();
    end
    expect_out("mul1_done", 1'b0, 1'b1, 1'b0, 1'b0, 4'h9, 24'h300000, 24'h123456, 1'b0, 1'b0);
    next_cycle();

    drive(A_MUL, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 4'h1, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 25; c++) begin
      expect_bubble($sformatf("mul2_stall_c%0d", c), 1'b1);
      next_cycle();
    end
    expect_out("mul2_done", 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 24'h000001, 24'h000000, 1'b0, 1'b0);
    next_cycle();
    drive(A_ADD, 24'h000003, 24'h000004, 24'h000042, 4'h2, 1'b1, 1'b0, 1'b0);
    expect_out("add_after_mul", 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 24'h000007, 24'h000042, 1'b0,
               1'b0);
    next_cycle();

    // Flush in busy cycle 10 abandons the multiply.
    drive(A_MUL, 24'h000010, 24'h000010, 24'h000000, 4'h4, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      expect_bubble($sformatf("mul3_stall_c%0d", c), 1'b1);
      next_cycle();
    end
    flush = 1'b1;
    expect_bubble("mul3_flush", 1'b0);
    next_cycle();
    flush    = 1'b0;
    valid_in = 1'b0;
    for (int c = 0; c < 20; c++) begin
      expect_bubble($sformatf("mul3_after_flush_c%0d", c), 1'b0);
      next_cycle();
    end
    drive(A_ADD, 24'h000001, 24'h000001, 24'h000000, 4'h3, 1'b1, 1'b0, 1'b0);
    expect_out("add_after_flush", 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 24'h000002, 24'h000000, 1'b0,
               1'b0);
    next_cycle();

    // valid_in dropping mid-multiply: stall continues, completion is a bubble.
    drive(A_MUL, 24'h000002, 24'h000003, 24'h0000AA, 4'h6, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 25; c++) begin
      if (c == 3) valid_in = 1'b0;
      if (c == 4) valid_in = 1'b1;
      expect_bubble($sformatf("mul4_stall_c%0d", c), 1'b1);
      next_cycle();
    end
    expect_bubble("mul4_done_dropped", 1'b0);
    next_cycle();
    valid_in = 1'b0;
    expect_bubble("mul4_idle", 1'b0);
    next_cycle();

    // Reset at busy cycle 5 for two cycles, then a SUB completes immediately.
    drive(A_MUL, 24'h000005, 24'h000007, 24'h000000, 4'h3, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      expect_bubble($sformatf("mul5_stall_c%0d", c), 1'b1);
      next_cycle();
    end
    rst = 1'b0;
    expect_bubble("mul5_rst_c0", 1'b0);
    next_cycle();
    expect_bubble("mul5_rst_c1", 1'b0);
    next_cycle();
    rst = 1'b1;
    drive(A_SUB, 24'h000005, 24'h000007, 24'h000077, 4'h8, 1'b1, 1'b0, 1'b0);
    expect_out("sub_after_rst", 1'b0, 1'b1, 1'b0, 1'b0, 4'h8, 24'hFFFFFE, 24'h000077, 1'b0,
               1'b1);
    next_cycle();
    valid_in = 1'b0;
    for (int c = 0; c < 25; c++) begin
      expect_bubble($sformatf("post_rst_idle_c%0d", c), 1'b0);
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 24, datapath width.
REQ-002 SHALL have parameter DEST_W, default 4, destination-register index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have inputs valid_in (1), flush (1), alu_op (4), operand_a (24), operand_b (24), store_data (24).
  - valid_in: an instruction is present.
  - flush: abort the in-flight operation.
REQ-006 SHALL have inputs writeback_enable, mem_read_enable, mem_write_enable (1 each) and instruction_dest (4); these are control carried from decode.
REQ-007 SHALL have output stall (1); high means upstream holds all inputs stable.
REQ-008 SHALL have outputs writeback_enable_out, mem_read_enable_out, mem_write_enable_out (1 each), instruction_dest_out (4), alu_result (24), write_data (24), zero_flag (1) and negative_flag (1); all feed the ALU-to-memory pipe register.

Function
REQ-009 SHALL, for single-cycle ops, drive all outputs combinationally from the current inputs; latency to the pipe register SHALL be 0 cycles.
REQ-010 SHALL decode alu_op as follows:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA
  - 8 MUL, 9 PASS_B, 10 SLT (signed, result 1 or 0)
  - 11-15: result 0 with control passed through.
REQ-011 SHALL truncate ADD, SUB and MUL to 24 bits with no overflow flag; wrap-around is silent.
REQ-012 SHALL take the shift amount from operand_b[4:0].
  - Amount >=24: SLL/SRL give 0; SRA gives all copies of bit 23.
REQ-013 SHALL, for a bubble, drive all enables 0, result 0 and flags 0. A bubble is any of: valid_in=0, flush=1, rst=0, or stall=1.
REQ-014 SHALL drive write_data=store_data and instruction_dest_out=instruction_dest whenever the output is not a bubble.
REQ-015 SHALL set zero_flag = (alu_result==0) and negative_flag = alu_result[23] for non-bubble outputs.
REQ-016 SHALL implement the MUL FSM states IDLE, MUL_BUSY, MUL_DONE, with these transitions:
  - IDLE + valid_in + op MUL + !flush -> MUL_BUSY; load operands, clear accumulator and counter.
  - MUL_BUSY: one shift-add iteration per cycle; after iteration 24 (counter=23) -> MUL_DONE.
  - MUL_DONE -> IDLE unconditionally.
REQ-017 SHALL assert stall combinationally in the MUL issue cycle (IDLE) and in every MUL_BUSY cycle.
  - stall is high exactly 25 consecutive cycles.
REQ-018 SHALL, in MUL_DONE, deassert stall and present the low 24 bits of the product with the held control as a normal non-bubble output.
REQ-019 SHALL, on flush=1 in any state, go to IDLE at the next edge, deassert stall combinationally and output a bubble.
REQ-020 SHALL treat flush=1 with rst=0 as reset; reset has priority.
REQ-021 SHALL, when valid_in drops during MUL_BUSY (protocol violation), continue the multiply and emit a bubble in MUL_DONE.
REQ-022 SHALL produce a product equal to the low 24 bits of operand_a*operand_b; signed and unsigned inputs give identical bits.

Reset
REQ-023 SHALL, when rst=0 at a rising edge, set state=IDLE, counter=0, accumulator=0 and the operand registers to 0.
REQ-024 SHALL, while rst=0, hold stall=0 and all outputs as a bubble (all zero).
REQ-025 SHALL, when reset is applied mid-MUL, abandon the operation with no result emitted; the first post-reset cycle is IDLE.

Structure
REQ-026 SHALL place the following in shared package cpu_pkg:
  - alu_op_t enum, DATA_W, DEST_W
  - exec_state_t enum (IDLE, MUL_BUSY, MUL_DONE)
  - MUL_ITERS=24
REQ-027 SHALL implement the iterative multiplier as sub-module seq_multiplier with ports start, flush, busy, done and product; execute_stage instantiates it once.

Verification
REQ-028 SHALL cover: ADD 0xFFFFFF+0x000002, dest 5, wb=1 -> same cycle alu_result=0x000001, zero=0, dest_out=5, stall=0.
REQ-029 SHALL cover: SRA 0x800000 by 30 -> 0xFFFFFF, negative=1; SLL 0x000001 by 24 -> 0x000000, zero=1.
REQ-030 SHALL cover: MUL 0x001000*0x000300, held 25 cycles -> stall high cycles 0-24 with bubbles; cycle 25 alu_result=0x300000, stall=0.
REQ-031 SHALL cover: MUL 0xFFFFFF*0xFFFFFF -> 0x000001 after 25 stall cycles; next cycle ADD accepted with no stall.
REQ-032 SHALL cover: MUL issued, flush=1 at busy cycle 10 -> next cycle stall=0, bubble output; FSM IDLE; no product emitted.
REQ-033 SHALL cover: rst=0 at busy cycle 5 for 2 cycles -> stall=0, all outputs 0; after release a new SUB 5-7 gives 0xFFFFFE immediately.
